// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device byte transmitter with ACK/NACK/timeout report
//
// Ports:
//   clk14       14 MHz master clock
//   rst_n       asynchronous active-low reset
//   tx_data     byte to send, captured when tx_start is accepted
//   tx_start    one-cycle request strobe, honoured only when idle
//   ps2_clk_in  raw PS/2 clock pin level
//   ps2_dat_in  raw PS/2 data pin level
//   ps2_clk_oe  1 = pull clock line low (open-drain)
//   ps2_dat_oe  1 = pull data line low (open-drain)
//   busy        transaction in progress; keyboard receiver must ignore the lines
//   done        one-cycle pulse at end of transaction
//   ack_ok      device acknowledged; held until the next accepted start
//   error       NACK or watchdog timeout; held until the next accepted start

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1568,
    parameter int TIMEOUT_CYCLES = 210000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk14,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       error
);

    // One counter serves both the inhibit delay and the watchdog.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int FW      = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t        state, state_next;
    logic [1:0]    sync1, sync2, filt;     // bit 0 = clock, bit 1 = data
    logic [FW-1:0] fcnt [2];
    logic          filt_clk_d;
    logic          fall;
    logic          timeout;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_cnt;
    logic [9:0]    shift;
    logic          dat_drv;

    // Synchronise both pins, then accept a new level only after it has been
    // seen on FILTER_LEN consecutive cycles.
    always_ff @(posedge clk14 or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 2'b11;
            sync2      <= 2'b11;
            filt       <= 2'b11;
            fcnt[0]    <= '0;
            fcnt[1]    <= '0;
            filt_clk_d <= 1'b1;
        end else begin
            sync1      <= {ps2_dat_in, ps2_clk_in};
            sync2      <= sync1;
            filt_clk_d <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FW'(1);
                end
            end
        end
    end

    assign fall = filt_clk_d & ~filt[0];

    always_ff @(posedge clk14 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        timeout    = 1'b0;
        case (state)
            IDLE:    if (tx_start) state_next = INHIBIT;
            INHIBIT: if (cnt == CW'(INHIBIT_CYCLES - 1)) state_next = REQ;
            REQ:     state_next = SEND;
            SEND, ACK, WAIT_IDLE: begin
                // Watchdog wins over a fall seen in the same cycle.
                if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end else if (state == SEND && fall && bit_cnt == 4'd9) begin
                    state_next = ACK;
                end else if (state == ACK && fall) begin
                    state_next = WAIT_IDLE;
                end else if (state == WAIT_IDLE && filt == 2'b11) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The start bit is driven from REQ and held into SEND until the first fall.
    assign ps2_clk_oe = (state == INHIBIT) || (state == REQ);
    assign ps2_dat_oe = (state == REQ) || (state == SEND && dat_drv);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk14 or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            dat_drv <= 1'b0;
            done    <= 1'b0;
            ack_ok  <= 1'b0;
            error   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (tx_start) begin
                        shift   <= {1'b1, ~^tx_data, tx_data};
                        bit_cnt <= '0;
                        ack_ok  <= 1'b0;
                        error   <= 1'b0;
                    end
                end
                INHIBIT: cnt <= (state_next == REQ) ? '0 : cnt + CW'(1);
                REQ: begin
                    cnt     <= '0;
                    dat_drv <= 1'b1;
                end
                SEND, ACK, WAIT_IDLE: begin
                    if (timeout) begin
                        cnt     <= '0;
                        dat_drv <= 1'b0;
                        error   <= 1'b1;
                        ack_ok  <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        cnt <= fall ? '0 : cnt + CW'(1);
                        if (fall && bit_cnt != 4'hF) bit_cnt <= bit_cnt + 4'd1;
                        if (state == SEND && fall) begin
                            dat_drv <= ~shift[0];
                            shift   <= {1'b0, shift[9:1]};
                        end
                        if (state == ACK && fall) begin
                            ack_ok <= ~filt[1];
                            error  <= filt[1];
                        end
                        if (state == WAIT_IDLE && state_next == IDLE) done <= 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - randomized self-checking bench for ps2_host_tx with a PS/2 device model

module tb_ps2_host_tx;

    localparam int INH  = 1568;
    localparam int TO   = 3000;
    localparam int HALF = 40;

    logic       clk14 = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       glitch = 1'b0;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe, busy, done, ack_ok, error;
    logic       clk_line, dat_line;

    // Open-drain bus: either side may pull low.
    assign clk_line   = ~(ps2_clk_oe | dev_clk_low);
    assign dat_line   = ~(ps2_dat_oe | dev_dat_low);
    assign ps2_clk_in = clk_line & ~glitch;
    assign ps2_dat_in = dat_line;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN    (8)
    ) dut (
        .clk14     (clk14),
        .rst_n     (rst_n),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .busy      (busy),
        .done      (done),
        .ack_ok    (ack_ok),
        .error     (error)
    );

    always #5 clk14 = ~clk14;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor: inhibit length, SEND entry time, and conditions at each done pulse.
    int   cyc = 0, done_cnt = 0, inh_run = 0, inh_len = 0;
    int   send_start = 0, done_cyc = 0;
    logic prev_req = 1'b0, done_lines_hi = 1'b0;
    logic [1:0] done_oe = 2'b00;

    always @(negedge clk14) begin
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc      = cyc;
            done_lines_hi = clk_line & dat_line;
            done_oe       = {ps2_clk_oe, ps2_dat_oe};
        end
        if (ps2_clk_oe && !ps2_dat_oe) inh_run++;
        else begin
            if (inh_run > 0) inh_len = inh_run;
            inh_run = 0;
        end
        if (prev_req && !ps2_clk_oe) send_start = cyc;
        prev_req = ps2_clk_oe & ps2_dat_oe;
    end

    // Device side: waits for the request-to-send, generates 11 clocks, samples
    // data on each rising edge, and on clock 11 pulls data low unless NACKing.
    task automatic device(input bit nack, input bit do_glitch, input int abort_at,
                          output logic [10:0] bits);
        int t;
        bits = '0;
        t = 0;
        while (!(clk_line && !dat_line) && t < 5000) begin
            @(negedge clk14);
            t++;
        end
        if (t >= 5000) begin
            check("req_seen", 0, 1);
            return;
        end
        repeat (HALF) @(negedge clk14);
        for (int i = 1; i <= 11; i++) begin
            if (i == 11 && !nack) begin
                dev_dat_low = 1'b1;
                repeat (5) @(negedge clk14);
            end
            dev_clk_low = 1'b1;
            if (i == abort_at) begin
                repeat (20) @(negedge clk14);
                return;
            end
            repeat (HALF) @(negedge clk14);
            dev_clk_low = 1'b0;
            bits[i-1] = dat_line;
            if (do_glitch && i == 4) begin
                repeat (10) @(negedge clk14);
                glitch = 1'b1;
                repeat (3) @(negedge clk14);
                glitch = 1'b0;
                repeat (HALF - 13) @(negedge clk14);
            end else begin
                repeat (HALF) @(negedge clk14);
            end
            if (i == 11) dev_dat_low = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit nack, input bit do_glitch,
                        input bit second_start, input int abort_at);
        logic [10:0] bits;
        int d0;
        logic exp_par;
        d0 = done_cnt;
        @(negedge clk14);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk14);
        tx_start = 1'b0;
        check("busy_t1", busy, 1);
        check("clk_oe_t1", ps2_clk_oe, 1);
        check("ack_clr", {ack_ok, error}, 0);
        if (second_start) begin
            tx_data  = ~b;
            tx_start = 1'b1;
            @(negedge clk14);
            tx_start = 1'b0;
            tx_data  = 8'h00;
        end
        device(nack, do_glitch, abort_at, bits);
        if (abort_at != 0) return;
        repeat (60) @(negedge clk14);
        exp_par = ($countones(b) % 2 == 0);
        check("inhibit_len", inh_len, INH);
        check("data_bits", bits[7:0], b);
        check("parity", bits[8], exp_par);
        check("stop", bits[9], 1);
        check("done_pulses", done_cnt - d0, 1);
        check("done_lines_hi", done_lines_hi, 1);
        check("ack_ok", ack_ok, !nack);
        check("error", error, nack);
        check("idle_end", {busy, ps2_clk_oe, ps2_dat_oe}, 0);
    endtask

    initial begin
        logic [7:0] rb;
        int d0, t;
        repeat (3) @(negedge clk14);
        check("rst_outs", {ps2_clk_oe, ps2_dat_oe, busy, done, ack_ok, error}, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk14);

        send(8'hED, 0, 0, 0, 0);
        send(8'h01, 0, 0, 0, 0);
        send(8'h00, 0, 0, 0, 0);
        send(8'hFF, 0, 0, 0, 0);
        send(8'h5A, 1, 0, 0, 0);
        send(8'hA5, 0, 1, 1, 0);

        // No device response: watchdog must end the transaction.
        d0 = done_cnt;
        @(negedge clk14);
        tx_data  = 8'hF4;
        tx_start = 1'b1;
        @(negedge clk14);
        tx_start = 1'b0;
        t = 0;
        while (done_cnt == d0 && t < INH + TO + 200) begin
            @(negedge clk14);
            t++;
        end
        #1;
        check("to_done", done_cnt - d0, 1);
        check("to_latency", done_cyc - send_start, TO);
        check("to_flags", {ack_ok, error}, 2'b01);
        check("to_oe", done_oe, 0);
        repeat (20) @(negedge clk14);
        check("to_idle", busy, 0);

        // Asynchronous reset in the middle of a frame.
        send(8'h3C, 0, 0, 0, 0);
        send(8'h00, 0, 0, 0, 5);
        check("pre_rst_dat_oe", ps2_dat_oe, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst", {ps2_clk_oe, ps2_dat_oe, busy, done, ack_ok, error}, 0);
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (5) @(negedge clk14);
        rst_n = 1'b1;
        repeat (20) @(negedge clk14);
        send(8'hC3, 0, 0, 0, 0);

        for (int k = 0; k < 4; k++) begin
            rb = 8'($urandom);
            send(rb, ($urandom_range(0, 3) == 0), 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
